// File: rtl/pla_pkg.sv
// Shared constants, clog2 helper and the max-width term record for the PLA evaluator.
package pla_pkg;

  localparam int N_IN_DEF    = 10;
  localparam int N_OUT_DEF   = 4;
  localparam int N_TERMS_DEF = 32;
  localparam int MAX_IN      = 32;
  localparam int MAX_OUT     = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Stored zero-extended; bits above the instance widths are always 0.
  typedef struct packed {
    logic [MAX_IN-1:0]  care;
    logic [MAX_IN-1:0]  val;
    logic [MAX_OUT-1:0] out;
  } pla_term_t;

endpackage

// File: rtl/pla_term_match.sv
// Single-cube compare: hit when every cared literal agrees and the slot drives something.
module pla_term_match
  import pla_pkg::*;
(
  input  pla_term_t          term,
  input  logic [MAX_IN-1:0]  data,
  output logic               hit
);

  assign hit = (((data ^ term.val) & term.care) == '0) && (term.out != '0);

endmodule

// File: rtl/pla_seq_eval.sv
// Two-stage runtime-programmable AND-OR evaluator with valid/ready on both sides.
// Optional output phase register enabled by defining PLA_OUT_PHASE_EN.
module pla_seq_eval
  import pla_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int N_TERMS = N_TERMS_DEF,
  localparam int AW     = clog2(N_TERMS),
  localparam int HW     = clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic [HW-1:0]    out_hits,
  input  logic             cfg_we,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_out
);

  localparam int STAGES = 2;
  localparam logic [HW-1:0] HIT_ONE = 1;

  pla_term_t [N_TERMS-1:0] terms;
  pla_term_t               wr_term;
  logic [STAGES:1]         vld_pipe;
  logic [N_TERMS-1:0]      match_vec, match_q;
  logic [MAX_IN-1:0]       data_ext;
  logic [N_OUT-1:0]        or_plane, res_data;
  logic [HW-1:0]           hits;
  logic                    stall2, hold1, in_fire, cfg_fire, slot_we;

  assign stall2    = vld_pipe[2] & ~out_ready;
  assign hold1     = vld_pipe[1] & stall2;
  assign in_ready  = ~hold1 & ~cfg_we;
  assign in_fire   = in_valid & in_ready;
  assign cfg_ready = ~vld_pipe[1] & ~vld_pipe[2] & ~in_valid;
  assign cfg_fire  = cfg_we & cfg_ready;
  assign out_valid = vld_pipe[2];

  always_comb begin
    data_ext = '0;
    data_ext[N_IN-1:0] = in_data;
    wr_term = '0;
    wr_term.care[N_IN-1:0] = cfg_care;
    wr_term.val[N_IN-1:0]  = cfg_val;
    wr_term.out[N_OUT-1:0] = cfg_out;
  end

  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    pla_term_match u_match (
      .term (terms[t]),
      .data (data_ext),
      .hit  (match_vec[t])
    );
  end

`ifdef PLA_OUT_PHASE_EN
  logic [N_OUT-1:0] phase;
  logic             phase_sel;

  // Last slot with a full care mask is reserved as the phase-register address.
  assign phase_sel = (int'(cfg_addr) == N_TERMS - 1) && (&cfg_care);
  assign slot_we   = cfg_fire & ~phase_sel;
  assign res_data  = or_plane ^ phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        phase <= '0;
    else if (cfg_fire && phase_sel) phase <= cfg_out;
  end
`else
  assign slot_we  = cfg_fire;
  assign res_data = or_plane;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      terms <= '0;
    else if (slot_we && (int'(cfg_addr) < N_TERMS))
      terms[cfg_addr] <= wr_term;
  end

  // Terms cannot change while the pipeline holds data, so stage 2 reads them directly.
  always_comb begin
    or_plane = '0;
    hits     = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (match_q[t]) begin
        or_plane = or_plane | terms[t].out[N_OUT-1:0];
        hits     = hits + HIT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      match_q  <= '0;
      out_data <= '0;
      out_hits <= '0;
    end else begin
      if (!hold1) begin
        vld_pipe[1] <= in_fire;
        if (in_fire) match_q <= match_vec;
      end
      if (!stall2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data <= res_data;
          out_hits <= hits;
        end
      end
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Randomised + directed bench for pla_seq_eval against a term-list reference model.
module tb_pla_seq_eval;

  localparam int N_IN = 10, N_OUT = 4, N_TERMS = 32, AW = 5, HW = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready;
  logic [N_IN-1:0]  in_data = '0;
  logic             out_valid, out_ready = 1'b1;
  logic [N_OUT-1:0] out_data;
  logic [HW-1:0]    out_hits;
  logic             cfg_we = 1'b0, cfg_ready;
  logic [AW-1:0]    cfg_addr = '0;
  logic [N_IN-1:0]  cfg_care = '0, cfg_val = '0;
  logic [N_OUT-1:0] cfg_out = '0;

  pla_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_hits(out_hits),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_out(cfg_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N_OUT-1:0] d; int h; } exp_t;
  exp_t q[$];
  logic [N_IN-1:0]  m_care[N_TERMS], m_val[N_TERMS];
  logic [N_OUT-1:0] m_out[N_TERMS];
  logic [N_OUT-1:0] m_phase;
  int n_cmp = 0, n_err = 0;
  bit rnd_bp = 0;
  logic rdy_force = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_eval(input logic [N_IN-1:0] d);
    exp_t e;
    logic [N_OUT-1:0] acc;
    acc = '0;
    e.h = 0;
    for (int t = 0; t < N_TERMS; t++)
      if (m_out[t] != 0 && ((d ^ m_val[t]) & m_care[t]) == 0) begin
        acc |= m_out[t];
        e.h++;
      end
    e.d = acc ^ m_phase;
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Scoreboard: q holds every accepted vector not yet consumed by the sink.
  always @(negedge clk) begin
    int occ;
    bit cfg_acc;
    if (!rst) begin
      occ = q.size();
      cfg_acc = cfg_we && occ == 0 && !in_valid;
      if (cfg_we) chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, cfg_acc});
      if (occ == 2 && !out_ready) chk("in_ready_full", {31'd0, in_ready}, 0);
      if (occ == 0 && !cfg_we) chk("in_ready_idle", {31'd0, in_ready}, 1);
      if (cfg_acc) begin
`ifdef PLA_OUT_PHASE_EN
        if (int'(cfg_addr) == N_TERMS - 1 && cfg_care == '1) m_phase = cfg_out;
        else
`endif
        begin
          m_care[cfg_addr] = cfg_care;
          m_val[cfg_addr]  = cfg_val;
          m_out[cfg_addr]  = cfg_out;
        end
      end
      if (in_valid && in_ready) q.push_back(model_eval(in_data));
      if (out_valid) begin
        if (occ == 0) chk("sb_empty", {31'd0, out_valid}, 0);
        else begin
          chk("sb_data", 32'(out_data), 32'(q[0].d));
          chk("sb_hits", 32'(out_hits), q[0].h);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    for (int t = 0; t < N_TERMS; t++) begin m_care[t] = '0; m_val[t] = '0; m_out[t] = '0; end
    m_phase = '0;
    #1 chk("rst_out_valid", {31'd0, out_valid}, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_hits", 32'(out_hits), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_accept", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int a, input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                           input logic [N_OUT-1:0] o);
    int n;
    n = 0;
    cfg_addr = AW'(a); cfg_care = c; cfg_val = v; cfg_out = o;
    cfg_we = 1'b1;
    @(negedge clk);
    while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
    chk("cfg_accept", {31'd0, cfg_ready}, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [N_OUT-1:0] d, input int h, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk({tag, "_valid"}, {31'd0, out_valid}, 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_hits"}, 32'(out_hits), h);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((out_valid || q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("idle", {30'd0, out_valid, q.size() != 0}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc, idx;
    logic [N_IN-1:0] bp[3];
    logic [N_IN-1:0] d;

    do_reset();

    // Empty PLA, with latency check.
    send(10'h3FF);
    expect_out("empty", 4'h0, 0, n);
    chk("latency", n, 2);

    // Single full-care term, back-to-back hit then miss.
    cfg_write(0, 10'h3FF, 10'h1DF, 4'b0010);
    send(10'h1DF);
    send(10'h1DE);
    expect_out("hit", 4'h2, 1, n);
    expect_out("miss", 4'h0, 0, n);
    chk("b2b", n, 1);

    // Constant-1 term plus slot 0.
    cfg_write(3, 10'h000, 10'h000, 4'hF);
    send(10'h1DF);
    expect_out("const", 4'hF, 2, n);

    // Backpressure: three vectors offered during five stalled cycles.
    bp[0] = 10'h1DF; bp[1] = 10'h123; bp[2] = 10'h1DE;
    rdy_force = 1'b0;
    acc = 0; idx = 0;
    in_data = bp[0]; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) begin
        acc++;
        @(posedge clk); #1;
        if (idx < 2) idx++;
        in_data = bp[idx];
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("bp_accepted", acc, 2);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Config attempt while stage 1 is occupied must be dropped.
    send(10'h2AA);
    cfg_addr = 5'd0; cfg_care = 10'h3FF; cfg_val = 10'h000; cfg_out = 4'h1;
    cfg_we = 1'b1;
    @(negedge clk);
    chk("cfg_busy", {31'd0, cfg_ready}, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_idle();
    send(10'h000);
    expect_out("cfg_kept", 4'hF, 1, n);

    // Reset mid-stream clears pipeline and slots.
    send(10'h1DF);
    send(10'h1DE);
    do_reset();
    send(10'h1DF);
    expect_out("post_rst", 4'h0, 0, n);

`ifdef PLA_OUT_PHASE_EN
    cfg_write(N_TERMS - 1, 10'h3FF, 10'h000, 4'hF);
    send(10'h155);
    expect_out("phase", 4'hF, 0, n);
`endif

    // Randomised traffic with random sink stalls.
    rnd_bp = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) begin
        cfg_write($urandom_range(0, N_TERMS - 1), N_IN'($urandom) | N_IN'($urandom),
                  N_IN'($urandom), ($urandom_range(0, 4) == 0) ? 4'h0 : N_OUT'($urandom));
      end else if (r == 1) begin
        @(posedge clk); #1;
      end else begin
        d = m_val[$urandom_range(0, N_TERMS - 1)];
        if ($urandom_range(0, 2) == 0) d ^= N_IN'(1 << $urandom_range(0, N_IN - 1));
        if ($urandom_range(0, 4) == 0) d = N_IN'($urandom);
        send(d);
      end
    end
    rnd_bp = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
